// File: rtl/fpdiv_ctrl_if.sv
// fpdiv_ctrl_if: request/operand handshake and datapath control lines between issuer, sequencer and fpdiv.
interface fpdiv_ctrl_if;
  logic        start;
  logic [31:0] inputNum;
  logic [31:0] inputDenom;
  logic        rm_in;
  logic [31:0] op_num;
  logic [31:0] op_denom;
  logic        rm;
  logic [1:0]  sel_mux4;
  logic [1:0]  sel_mux3;
  logic        en_a;
  logic        en_b;
  logic        en_rem;
  logic        busy;
  logic        done;
  modport master (
    output start, inputNum, inputDenom, rm_in,
    input  op_num, op_denom, rm, sel_mux4, sel_mux3, en_a, en_b, en_rem, busy, done
  );
  modport slave (
    input  start, inputNum, inputDenom, rm_in,
    output op_num, op_denom, rm, sel_mux4, sel_mux3, en_a, en_b, en_rem, busy, done
  );
endinterface

// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: Goldschmidt divider control sequencer; captures operands on start and
// Moore-decodes the fpdiv datapath selects/enables from the registered state.
module fpdiv_ctrl #(
  parameter int ITER = 6
) (
  input logic         clk,
  input logic         reset,
  fpdiv_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INIT_A, INIT_B, ITER_A, ITER_B, REM, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] num_q, num_d, den_q, den_d;
  logic        rm_q, rm_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      rm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      den_q   <= den_d;
      rm_q    <= rm_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    den_d   = den_q;
    rm_d    = rm_q;
    case (state_q)
      IDLE: if (bus.start) begin
        num_d   = bus.inputNum;
        den_d   = bus.inputDenom;
        rm_d    = bus.rm_in;
        cnt_d   = '0;
        state_d = INIT_A;
      end
      INIT_A: state_d = INIT_B;
      INIT_B: state_d = (ITER == 1) ? REM : ITER_A;
      ITER_A: state_d = ITER_B;
      ITER_B: begin
        // The initial scaling step counts as one iteration, hence ITER-1 pairs here.
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_d == 4'(ITER - 1)) ? REM : ITER_A;
      end
      REM:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.sel_mux4 = (state_q == INIT_B) ? 2'b01 :
                        (state_q == ITER_A || state_q == REM) ? 2'b10 :
                        (state_q == ITER_B) ? 2'b11 : 2'b00;
  assign bus.sel_mux3 = (state_q == ITER_A || state_q == ITER_B) ? 2'b01 :
                        (state_q == REM) ? 2'b10 : 2'b00;
  assign bus.en_a     = (state_q == INIT_A) || (state_q == ITER_A);
  assign bus.en_b     = (state_q == INIT_B) || (state_q == ITER_B);
  assign bus.en_rem   = (state_q == REM);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.op_num   = num_q;
  assign bus.op_denom = den_q;
  assign bus.rm       = rm_q;
endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb_fpdiv_ctrl: directed checks of fpdiv_ctrl sequencing with ITER=6 and ITER=1 instances.
module tb_fpdiv_ctrl;
  logic        clk, reset, start, rm_in;
  logic [31:0] num, den;
  int          vectors, miscompares;
  fpdiv_ctrl_if ifa();
  fpdiv_ctrl_if ifb();
  assign ifa.start = start;
  assign ifa.inputNum = num;
  assign ifa.inputDenom = den;
  assign ifa.rm_in = rm_in;
  assign ifb.start = start;
  assign ifb.inputNum = num;
  assign ifb.inputDenom = den;
  assign ifb.rm_in = rm_in;
  fpdiv_ctrl #(.ITER(6)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  fpdiv_ctrl #(.ITER(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (reset) begin
      vectors++;
      if ($countones({ifa.en_a, ifa.en_b, ifa.en_rem}) > 1 || $countones({ifb.en_a, ifb.en_b, ifb.en_rem}) > 1) begin
        miscompares++;
        $display("FAIL onehot_en a=%b b=%b want at most one set", {ifa.en_a, ifa.en_b, ifa.en_rem}, {ifb.en_a, ifb.en_b, ifb.en_rem});
      end
    end
  end
  task automatic launch(input logic [31:0] n, input logic [31:0] d, input logic r);
    @(negedge clk);
    num = n; den = d; rm_in = r; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((ifa.busy || ifb.busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (ifa.busy || ifb.busy) begin
      miscompares++;
      $display("FAIL wait_idle busy a=%b b=%b want 0 within 50 cycles", ifa.busy, ifb.busy);
    end
  endtask
  // Checks dut_a from cycle E0+1 through the IDLE cycle after done; call right after the accepting edge.
  task automatic check_seq(input string tag, input logic [31:0] n, input logic [31:0] d, input logic r);
    logic [8:0] exp_v, obs_v;
    logic [1:0] m4, m3;
    logic [2:0] en;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      m4 = (k == 1) ? 2'b00 : (k == 2) ? 2'b01 : (k == 13) ? 2'b10 : (k > 13) ? 2'b00 : (k % 2 == 1) ? 2'b10 : 2'b11;
      m3 = (k <= 2 || k > 13) ? 2'b00 : (k == 13) ? 2'b10 : 2'b01;
      en = (k > 13) ? 3'b000 : (k == 13) ? 3'b001 : (k % 2 == 1) ? 3'b100 : 3'b010;
      exp_v = {m4, m3, en, k <= 14, k == 14};
      obs_v = {ifa.sel_mux4, ifa.sel_mux3, ifa.en_a, ifa.en_b, ifa.en_rem, ifa.busy, ifa.done};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL %s ctrl cycle %0d got m4,m3,en,busy,done=%b want %b", tag, k, obs_v, exp_v);
      end
      vectors++;
      if ({ifa.op_num, ifa.op_denom, ifa.rm} !== {n, d, r}) begin
        miscompares++;
        $display("FAIL %s operands cycle %0d got %h/%h/%b want %h/%h/%b", tag, k, ifa.op_num, ifa.op_denom, ifa.rm, n, d, r);
      end
    end
  endtask
  task automatic test_reset();
    #1;
    vectors++;
    if ({ifa.sel_mux4, ifa.sel_mux3, ifa.en_a, ifa.en_b, ifa.en_rem, ifa.busy, ifa.done, ifa.op_num, ifa.op_denom, ifa.rm} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got num=%h den=%h busy=%b m4=%b want all zero", ifa.op_num, ifa.op_denom, ifa.busy, ifa.sel_mux4);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_sequence();
    launch(32'h9EDE38F7, 32'h3E7F7F7F, 1'b1);
    check_seq("seq", 32'h9EDE38F7, 32'h3E7F7F7F, 1'b1);
    wait_idle();
  endtask
  task automatic test_start_spam();
    int dones = 0;
    launch(32'h8683F7FF, 32'hC07F3FFF, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (ifa.done) dones++;
      vectors++;
      if ({ifa.op_num, ifa.op_denom, ifa.rm} !== {32'h8683F7FF, 32'hC07F3FFF, 1'b0}) begin
        miscompares++;
        $display("FAIL spam_operands cycle %0d got %h/%h/%b want 8683f7ff/c07f3fff/0", k, ifa.op_num, ifa.op_denom, ifa.rm);
      end
      start = (k < 14);
      num = 32'h12345678 + k;
      den = 32'h0BADF00D ^ k;
      rm_in = 1'b1;
    end
    vectors++;
    if (dones != 1 || ifa.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL spam_done got dones=%0d busy=%b want 1 and 0", dones, ifa.busy);
    end
    wait_idle();
  endtask
  task automatic test_back_to_back();
    launch(32'h8683F7FF, 32'hC07F3FFF, 1'b0);
    repeat (14) @(negedge clk);
    vectors++;
    if (ifa.done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first_done got %b want 1", ifa.done);
    end
    num = 32'h9EDE38F7; den = 32'h3E7F7F7F; rm_in = 1'b1; start = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ifa.busy, ifa.done, ifa.op_num} !== {2'b00, 32'h8683F7FF}) begin
      miscompares++;
      $display("FAIL b2b_gap got busy=%b done=%b num=%h want 0 0 8683f7ff", ifa.busy, ifa.done, ifa.op_num);
    end
    @(posedge clk);
    #1 start = 1'b0;
    check_seq("b2b", 32'h9EDE38F7, 32'h3E7F7F7F, 1'b1);
    wait_idle();
  endtask
  task automatic test_iter1();
    logic [8:0] exp_v, obs_v;
    launch(32'h9EDE38F7, 32'h3E7F7F7F, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp_v = (k == 1) ? 9'b00_00_100_1_0 : (k == 2) ? 9'b01_00_010_1_0 :
              (k == 3) ? 9'b10_10_001_1_0 : (k == 4) ? 9'b00_00_000_1_1 : 9'b0;
      obs_v = {ifb.sel_mux4, ifb.sel_mux3, ifb.en_a, ifb.en_b, ifb.en_rem, ifb.busy, ifb.done};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL iter1 cycle %0d got m4,m3,en,busy,done=%b want %b", k, obs_v, exp_v);
      end
    end
    wait_idle();
  endtask
  task automatic test_reset_mid();
    launch(32'h8683F7FF, 32'hC07F3FFF, 1'b0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({ifa.sel_mux4, ifa.sel_mux3, ifa.en_a, ifa.en_b, ifa.en_rem, ifa.busy, ifa.done, ifa.op_num, ifa.op_denom, ifa.rm} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid got num=%h busy=%b en=%b%b%b m4=%b want all zero", ifa.op_num, ifa.busy, ifa.en_a, ifa.en_b, ifa.en_rem, ifa.sel_mux4);
    end
    @(negedge clk);
    reset = 1'b1;
    launch(32'h9EDE38F7, 32'h3E7F7F7F, 1'b1);
    check_seq("post_reset", 32'h9EDE38F7, 32'h3E7F7F7F, 1'b1);
    wait_idle();
  endtask
  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; start = 1'b0; rm_in = 1'b0; num = '0; den = '0;
    test_reset();
    test_sequence();
    test_start_spam();
    test_back_to_back();
    test_iter1();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
